// File: rtl/led_history_display_if.sv
// led_history_display_if: LED code in, hold control and seven-segment display outputs.
interface led_history_display_if;
    logic [3:0] led_in;
    logic       hold;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig_en;
    logic [7:0] change_cnt;
    modport master(output led_in, hold, input seg, dp, dig_en, change_cnt);
    modport slave(input led_in, hold, output seg, dp, dig_en, change_cnt);
endinterface

// File: rtl/led_history_display.sv
// led_history_display: shows the four most recent distinct LED codes on a 4-digit multiplexed seven-segment display.
module led_history_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input logic                  clk_50Mhz,
    input logic                  res,
    led_history_display_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic [3:0]    s1, s2, s3;
    logic [3:0]    hist [4];
    logic [3:0]    valid;
    logic [7:0]    cnt;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic [3:0]    dig_q;
    logic          push, tick;
    // s3 follows s2 even while held, so a change seen during hold is lost for good
    assign push = s2 != s3 && !bus.hold;
    assign tick = presc == PW'(REFRESH_DIV - 1);
    always_ff @(posedge clk_50Mhz) begin
        if (res) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            hist  <= '{default: '0};
            valid <= '0;
            cnt   <= '0;
            presc <= '0;
            idx   <= '0;
            seg_q <= '0;
            dp_q  <= 1'b0;
            dig_q <= '0;
        end else begin
            s1    <= bus.led_in;
            s2    <= s1;
            s3    <= s2;
            if (push) begin
                hist  <= '{s2, hist[0], hist[1], hist[2]};
                valid <= {valid[2:0], 1'b1};
                cnt   <= cnt + {7'd0, cnt != 8'hFF};
            end
            presc <= tick ? '0 : presc + 1'b1;
            idx   <= idx + 2'(tick);
            dig_q <= 4'b0001 << idx;
            seg_q <= valid[idx] ? SEG_LUT[hist[idx]] : 7'h00;
            dp_q  <= bus.hold && idx == 2'd0;
        end
    end
    assign bus.seg        = seg_q ^ {7{SEG_ACTIVE_LOW}};
    assign bus.dp         = dp_q ^ SEG_ACTIVE_LOW;
    assign bus.dig_en     = dig_q ^ {4{SEG_ACTIVE_LOW}};
    assign bus.change_cnt = cnt;
endmodule

// File: tb/tb_led_history_display.sv
// tb_led_history_display: cycle-by-cycle comparison against a queue-based history model plus directed literal checks.
module tb_led_history_display;
    localparam int DIV = 4;
    logic clk_50Mhz = 1'b0;
    logic res;
    led_history_display_if bus();
    led_history_display #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk_50Mhz(clk_50Mhz),
        .res(res),
        .bus(bus)
    );
    always #10 clk_50Mhz = ~clk_50Mhz;

    int total = 0;
    int bad = 0;
    logic [6:0] lut [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: history as a newest-first queue, scan slot from elapsed cycles since reset
    logic [3:0] hq [$];
    logic [3:0] p1, p2, p3;
    int cyc = 0;
    int e_cnt = 0;
    int e_seg, e_dp, e_dig;
    bit started = 0;
    always @(posedge clk_50Mhz) begin
        if (res) begin
            hq.delete();
            {p1, p2, p3} = '0;
            cyc = 0;
            e_cnt = 0;
            e_seg = 0;
            e_dp = 0;
            e_dig = 0;
        end else begin
            int i;
            i = (cyc / DIV) % 4;
            e_dig = 1 << i;
            e_seg = i < hq.size() ? int'(lut[hq[i]]) : 0;
            e_dp = (bus.hold && i == 0) ? 1 : 0;
            if (!bus.hold && p2 != p3) begin
                hq.push_front(p2);
                if (hq.size() > 4) void'(hq.pop_back());
                e_cnt = e_cnt < 255 ? e_cnt + 1 : 255;
            end
            p3 = p2;
            p2 = p1;
            p1 = bus.led_in;
            cyc++;
        end
        started = 1;
    end

    always @(negedge clk_50Mhz) begin
        if (started) begin
            chk("seg", int'(bus.seg), e_seg);
            chk("dp", int'(bus.dp), e_dp);
            chk("dig_en", int'(bus.dig_en), e_dig);
            chk("change_cnt", int'(bus.change_cnt), e_cnt);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_50Mhz);
    endtask

    task automatic scan(input string nm, input logic [6:0] l0, l1, l2, l3);
        logic [6:0] l [4];
        l = '{l0, l1, l2, l3};
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_50Mhz);
            for (int d = 0; d < 4; d++)
                if (bus.dig_en == 4'(1 << d)) chk(nm, int'(bus.seg), int'(l[d]));
        end
    endtask

    initial begin
        res = 1'b1;
        bus.led_in = 4'h5;
        bus.hold = 1'b0;
        cycles(3);
        chk("rst_dig", int'(bus.dig_en), 0);
        chk("rst_seg", int'(bus.seg), 0);
        res = 1'b0;
        cycles(1);
        chk("first_dig", int'(bus.dig_en), 1);
        chk("first_seg", int'(bus.seg), 0);
        cycles(1);
        chk("no_push_yet", int'(bus.change_cnt), 0);
        cycles(1);
        chk("push5_cnt", int'(bus.change_cnt), 1);
        cycles(1);
        chk("push5_seg", int'(bus.seg), 'h6D);

        res = 1'b1;
        bus.led_in = 4'h0;
        cycles(1);
        res = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            bus.led_in = 4'(v);
            cycles(20);
        end
        chk("seq_cnt", int'(bus.change_cnt), 4);
        scan("seq_scan", 7'h66, 7'h4F, 7'h5B, 7'h06);

        bus.hold = 1'b1;
        bus.led_in = 4'h9;
        cycles(20);
        bus.led_in = 4'hA;
        cycles(20);
        chk("hold_cnt", int'(bus.change_cnt), 4);
        bus.hold = 1'b0;
        cycles(20);
        chk("post_hold_cnt", int'(bus.change_cnt), 4);
        scan("hold_scan", 7'h66, 7'h4F, 7'h5B, 7'h06);

        bus.led_in = 4'h7;
        cycles(20);
        chk("lat_pre", int'(bus.change_cnt), 5);
        bus.led_in = 4'hF;
        cycles(1);
        chk("lat_k", int'(bus.change_cnt), 5);
        cycles(1);
        chk("lat_k1", int'(bus.change_cnt), 5);
        cycles(1);
        chk("lat_k2", int'(bus.change_cnt), 6);
        cycles(100);
        chk("no_repeat", int'(bus.change_cnt), 6);
        scan("lat_scan", 7'h71, 7'h07, 7'h66, 7'h4F);

        for (int i = 0; i < 300; i++) begin
            bus.led_in = 4'(i % 2);
            cycles(4);
        end
        cycles(4);
        chk("sat_cnt", int'(bus.change_cnt), 255);
        scan("sat_scan", 7'h06, 7'h3F, 7'h06, 7'h3F);

        begin
            int w = 0;
            while (bus.dig_en != 4'b0100 && w < 20) begin
                cycles(1);
                w++;
            end
            chk("wait_idx2", w < 20 ? 1 : 0, 1);
        end
        res = 1'b1;
        cycles(1);
        chk("mid_rst_dig", int'(bus.dig_en), 0);
        chk("mid_rst_seg", int'(bus.seg), 0);
        chk("mid_rst_cnt", int'(bus.change_cnt), 0);
        res = 1'b0;
        cycles(1);
        chk("mid_rst_idx0", int'(bus.dig_en), 1);
        chk("mid_rst_blank", int'(bus.seg), 0);
        cycles(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
